// File: rtl/radix4_booth_seq.sv
// rtl/radix4_booth_seq.sv - sequential radix-4 Booth signed multiplier
//
// Purpose:
//   Signed WIDTH x WIDTH multiplier that adds one radix-4 Booth partial
//   product per clock into a shared 2*WIDTH accumulator. It takes one
//   operation at a time and holds the product until the consumer takes it.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   requester presents operands on a/b
//   in_ready   block can accept an operation (IDLE)
//   a          multiplicand, two's complement
//   b          multiplier, two's complement
//   out_valid  result is valid (DONE)
//   out_ready  consumer accepts result
//   result     full-width signed product a*b
//   busy       operation in flight or result pending

module radix4_booth_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               busy
);

  localparam int N  = WIDTH / 2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int MW = WIDTH + 2;
  localparam int RW = 2 * WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [MW-1:0]     m_q, m_d;
  logic [WIDTH:0]    q_q, q_d;
  logic [RW-1:0]     acc_q, acc_d;
  logic [RW-1:0]     res_q, res_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [MW-1:0]     pp;
  logic [RW-1:0]     pp_ext;
  logic [RW-1:0]     acc_sum;

  // M is held with two extra sign bits so that 2M and -2M are exact even
  // for the most negative multiplicand.
  always_comb begin
    pp = '0;
    unique case (q_q[2:0])
      3'b001, 3'b010: pp = m_q;
      3'b011:         pp = m_q << 1;
      3'b100:         pp = -(m_q << 1);
      3'b101, 3'b110: pp = -m_q;
      default:        pp = '0;
    endcase
  end

  // Sign-extend the partial product to full width and weight it by 4^count;
  // bits pushed past the top are dropped, matching modulo-2^(2W) addition.
  always_comb begin
    pp_ext  = {{(RW-MW){pp[MW-1]}}, pp};
    acc_sum = acc_q + (pp_ext << {cnt_q, 1'b0});
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    q_d     = q_q;
    acc_d   = acc_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          m_d     = {{2{a[WIDTH-1]}}, a};
          q_d     = {b, 1'b0};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d = acc_sum;
        q_d   = {{2{q_q[WIDTH]}}, q_q[WIDTH:2]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          res_d   = acc_sum;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      m_q     <= '0;
      q_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign result    = res_q;

endmodule
